// File: rtl/imem_fetch_requester.sv
// Instruction-fetch requester: one read outstanding, one-entry output buffer, redirect/flush.
// Build macro FETCH_TIMEOUT_EN adds a sticky wait-timeout flag on timeout_err_o.
module imem_fetch_requester #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter bit          WORD_ADDR      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o,
  output logic        mem_rreq_o,
  output logic [31:0] mem_raddr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_data_valid_i,
  output logic        busy_o
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic        timeout_err_o
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        rreq_q, rreq_d;
  logic [31:0] raddr_q, raddr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;

  function automatic logic [31:0] fetch_addr(input logic [31:0] pc);
    return WORD_ADDR ? {2'b00, pc[31:2]} : pc;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      rreq_q      <= 1'b0;
      raddr_q     <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      rreq_q      <= rreq_d;
      raddr_q     <= raddr_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  // A response that coincides with a redirect, or arrives while a kill is pending, is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (mem_data_valid_i) begin
          state_d = (kill_q || redirect_valid_i) ? StIdle : StHold;
        end
      end
      StHold: begin
        if (redirect_valid_i || out_ready_i) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    kill_d      = kill_q;
    rreq_d      = rreq_q;
    raddr_d     = raddr_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    unique case (state_q)
      StIdle: begin
        pc_d        = redirect_valid_i ? redirect_pc_i : pc_q;
        rreq_d      = 1'b1;
        raddr_d     = fetch_addr(pc_d);
        out_valid_d = 1'b0;
      end
      StReq: begin
        if (redirect_valid_i) pc_d = redirect_pc_i;
        if (mem_data_valid_i) begin
          rreq_d = 1'b0;
          kill_d = 1'b0;
          if (!kill_q && !redirect_valid_i) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = mem_rdata_i;
          end
        end else if (redirect_valid_i) begin
          // Address stays put; the stale reply is swallowed when it lands.
          kill_d = 1'b1;
        end
      end
      StHold: begin
        if (redirect_valid_i || out_ready_i) begin
          pc_d        = redirect_valid_i ? redirect_pc_i : pc_q + 32'd4;
          out_valid_d = 1'b0;
          rreq_d      = 1'b1;
          raddr_d     = fetch_addr(pc_d);
        end
      end
      default: rreq_d = 1'b0;
    endcase
  end

  always_comb begin
    busy_o      = (state_q == StReq);
    mem_rreq_o  = rreq_q;
    mem_raddr_o = raddr_q;
    out_valid_o = out_valid_q;
    out_pc_o    = out_pc_q;
    out_instr_o = out_instr_q;
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [6:0] TimeoutVal = 7'(TIMEOUT_CYCLES);

  logic [6:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_err_q, timeout_err_d;

  // Counter saturates at the limit; the flag is sticky until reset.
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q != StReq) begin
      wait_cnt_d = '0;
    end else if (!mem_data_valid_i && wait_cnt_q != TimeoutVal) begin
      wait_cnt_d = wait_cnt_q + 7'd1;
      if (wait_cnt_d == TimeoutVal) timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err_o = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_imem_fetch_requester.sv
// Bench for imem_fetch_requester: directed steps, then random redirect/ready/latency traffic
// checked against a transaction-level pc/word model.
module tb_imem_fetch_requester;

  localparam logic [31:0] ResetPcTb = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, mem_rreq, busy;
  logic [31:0] out_pc, out_instr, mem_raddr;
  logic        mem_data_valid;
  logic [31:0] mem_rdata;
`ifdef FETCH_TIMEOUT_EN
  logic        timeout_err, timeout_err2;
`endif

  logic        out_valid2, mem_rreq2, busy2;
  logic [31:0] out_pc2, out_instr2, mem_raddr2;
  logic        dv2 = 1'b0, pend2 = 1'b0, prev2 = 1'b0;
  logic [31:0] rdata2 = '0, addr2 = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_fetch_requester #(.RESET_PC(ResetPcTb), .WORD_ADDR(1'b1), .TIMEOUT_CYCLES(63)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc), .out_instr_o(out_instr),
    .mem_rreq_o(mem_rreq), .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata),
    .mem_data_valid_i(mem_data_valid), .busy_o(busy)
`ifdef FETCH_TIMEOUT_EN
    , .timeout_err_o(timeout_err)
`endif
  );

  imem_fetch_requester #(.RESET_PC(32'hFFFF_FFFC), .WORD_ADDR(1'b1), .TIMEOUT_CYCLES(63)) dut2 (
    .clk(clk), .reset(reset),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0),
    .out_valid_o(out_valid2), .out_ready_i(1'b1), .out_pc_o(out_pc2), .out_instr_o(out_instr2),
    .mem_rreq_o(mem_rreq2), .mem_raddr_o(mem_raddr2), .mem_rdata_i(rdata2),
    .mem_data_valid_i(dv2), .busy_o(busy2)
`ifdef FETCH_TIMEOUT_EN
    , .timeout_err_o(timeout_err2)
`endif
  );

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory: a new request (rising rreq) answers with a one-cycle strobe delay+1 cycles later.
  int          mem_delay = 0;
  logic        mem_mute = 1'b0;
  logic        pend = 1'b0, prev_rreq = 1'b0, mem_dv_r = 1'b0;
  int          wcnt = 0;
  logic [31:0] lat_addr = '0, mem_rdata_r = '0;
  logic        spur_dv = 1'b0;
  logic [31:0] spur_data = '0;

  assign mem_data_valid = mem_dv_r | spur_dv;
  assign mem_rdata      = spur_dv ? spur_data : mem_rdata_r;

  always @(negedge clk) begin
    prev_rreq <= mem_rreq;
    mem_dv_r  <= pend && (wcnt == 0);
    if (pend && wcnt == 0) mem_rdata_r <= model_word(lat_addr);
    if (mem_rreq && !prev_rreq && !mem_mute) begin
      pend     <= 1'b1;
      wcnt     <= mem_delay;
      lat_addr <= mem_raddr;
    end else if (pend) begin
      if (wcnt == 0) pend <= 1'b0;
      else wcnt <= wcnt - 1;
    end
  end

  always @(negedge clk) begin
    prev2 <= mem_rreq2;
    pend2 <= mem_rreq2 && !prev2;
    addr2 <= mem_raddr2;
    dv2   <= pend2;
    if (pend2) rdata2 <= model_word(addr2);
  end

  // Reference model: next presented word's pc = last redirect since the last handshake,
  // else accepted pc + 4; every word must carry the memory content of its own address.
  logic        s_reset = 1'b1, s_ready = 1'b0, s_redir = 1'b0;
  logic [31:0] s_redir_pc = '0;
  logic        p_valid = 1'b0, p_rreq = 1'b0;
  logic [31:0] p_pc = '0, p_instr = '0, p_raddr = '0;
  logic [31:0] next_pc = ResetPcTb, np;
  int          cyc = 0, word_count = 0;
  logic [31:0] req_log[$], word_log[$], q2_pc[$], q2_addr[$];
  int          word_cyc[$];
  logic        p_valid2 = 1'b0, p_rreq2 = 1'b0;

  always @(posedge clk) begin
    s_reset    <= reset;
    s_ready    <= out_ready;
    s_redir    <= redirect_valid;
    s_redir_pc <= redirect_pc;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (s_reset) begin
      check("rst_valid", out_valid, 0);
      check("rst_rreq", mem_rreq, 0);
      check("rst_raddr", mem_raddr, 0);
      check("rst_pc", out_pc, 0);
      check("rst_instr", out_instr, 0);
      check("rst_busy", busy, 0);
      next_pc <= ResetPcTb;
    end else begin
      np = next_pc;
      if (p_valid && s_ready) np = p_pc + 32'd4;
      if (s_redir) np = s_redir_pc;
      next_pc <= np;
      check("rreq_in_hold", mem_rreq && out_valid, 0);
      if (p_rreq && mem_rreq) check("raddr_stable", mem_raddr, p_raddr);
      if (mem_rreq && !p_rreq) begin
        check("req_addr", mem_raddr, {2'b00, np[31:2]});
        req_log.push_back(mem_raddr);
      end
      if (out_valid && !p_valid) begin
        check("word_pc", out_pc, np);
        check("word_instr", out_instr, model_word({2'b00, out_pc[31:2]}));
        word_log.push_back(out_pc);
        word_cyc.push_back(cyc);
        word_count <= word_count + 1;
      end
      if (p_valid && !s_ready && !s_redir) begin
        check("hold_valid", out_valid, 1);
        check("hold_pc", out_pc, p_pc);
        check("hold_instr", out_instr, p_instr);
      end
      if (p_valid && (s_ready || s_redir)) check("valid_drop", out_valid, 0);
    end
    p_valid <= out_valid;
    p_pc    <= out_pc;
    p_instr <= out_instr;
    p_rreq  <= mem_rreq;
    p_raddr <= mem_raddr;
  end

  always @(negedge clk) begin
    if (out_valid2 && !p_valid2) begin
      q2_pc.push_back(out_pc2);
      check("w2_instr", out_instr2, model_word({2'b00, out_pc2[31:2]}));
    end
    if (mem_rreq2 && !p_rreq2) q2_addr.push_back(mem_raddr2);
    p_valid2 <= out_valid2;
    p_rreq2  <= mem_rreq2;
  end

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    reset = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    spur_dv = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b0;
    out_ready = rdy;
  endtask

  task automatic wait_req(input string tag, input int maxc);
    logic prev;
    int n;
    prev = mem_rreq;
    n = 0;
    @(negedge clk);
    while (!(mem_rreq && !prev) && n < maxc) begin
      prev = mem_rreq;
      @(negedge clk);
      n++;
    end
    check(tag, mem_rreq && !prev, 1);
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    int n;
    n = 0;
    while (!out_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, out_valid, 1);
  endtask

  initial begin
    int wsize, wstart;
    logic [31:0] rpc;

    // Zero-delay memory, ready high: words 0,4,8 every 3 cycles; wrap on the second instance.
    mem_delay = 0;
    do_reset(1'b1);
    req_log.delete(); word_log.delete(); word_cyc.delete(); q2_pc.delete(); q2_addr.delete();
    repeat (12) @(negedge clk);
    check("t1_nreq", req_log.size() >= 3, 1);
    check("t1_nwords", word_log.size() >= 3 && word_cyc.size() >= 3, 1);
    check("t1_raddr0", req_log[0], 32'h0);
    check("t1_raddr1", req_log[1], 32'h1);
    check("t1_raddr2", req_log[2], 32'h2);
    check("t1_pc0", word_log[0], 32'h0);
    check("t1_pc1", word_log[1], 32'h4);
    check("t1_pc2", word_log[2], 32'h8);
    check("t1_rate01", word_cyc[1] - word_cyc[0], 3);
    check("t1_rate12", word_cyc[2] - word_cyc[1], 3);
    check("wrap_n", q2_pc.size() >= 2 && q2_addr.size() >= 2, 1);
    check("wrap_addr0", q2_addr[0], 32'h3FFF_FFFF);
    check("wrap_pc0", q2_pc[0], 32'hFFFF_FFFC);
    check("wrap_addr1", q2_addr[1], 32'h0);
    check("wrap_pc1", q2_pc[1], 32'h0);

    // Delay 20, hold 5 cycles with a spurious strobe, then release.
    mem_delay = 20;
    do_reset(1'b0);
    wait_valid("t2_valid", 60);
    check("t2_pc", out_pc, 32'h0);
    check("t2_instr", out_instr, model_word(32'h0));
    spur_dv = 1'b1;
    spur_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      spur_dv = 1'b0;
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_pc", out_pc, 32'h0);
      check("t2_hold_instr", out_instr, model_word(32'h0));
      check("t2_hold_rreq", mem_rreq, 0);
      check("t2_hold_busy", busy, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t2_next_rreq", mem_rreq, 1);
    check("t2_next_raddr", mem_raddr, 32'h1);
    check("t2_next_busy", busy, 1);
    check("t2_valid_low", out_valid, 0);

    // Redirect to 0x100 three cycles into the request for pc 0x8.
    mem_delay = 20;
    do_reset(1'b1);
    wait_req("t3_req0", 10);
    wait_req("t3_req1", 60);
    wait_req("t3_req2", 60);
    check("t3_addr8", mem_raddr, 32'h2);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    wsize = word_log.size();
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t3_kill_raddr", mem_raddr, 32'h2);
    wait_req("t3_rereq", 60);
    check("t3_rereq_addr", mem_raddr, 32'h40);
    check("t3_no_stale_word", word_log.size(), wsize);
    wait_valid("t3_valid", 60);
    check("t3_pc", out_pc, 32'h100);
    check("t3_instr", out_instr, model_word(32'h40));

    // Redirect to 0x200 in the same cycle as the response strobe.
    mem_delay = 5;
    do_reset(1'b1);
    wait_req("t4_req", 10);
    repeat (6) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t4_gap_rreq", mem_rreq, 0);
    check("t4_gap_valid", out_valid, 0);
    check("t4_gap_busy", busy, 0);
    @(negedge clk);
    check("t4_rreq", mem_rreq, 1);
    check("t4_raddr", mem_raddr, 32'h80);

    // Reset mid-request; the old reply lands during reset and must be ignored.
    mem_delay = 20;
    do_reset(1'b1);
    wait_req("t5_req", 10);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    reset = 1'b0;
    wait_valid("t5_valid", 40);
    check("t5_pc", out_pc, 32'h0);
    check("t5_instr", out_instr, model_word(32'h0));

`ifdef FETCH_TIMEOUT_EN
    mem_mute = 1'b1;
    do_reset(1'b1);
    wait_req("to_req", 10);
    repeat (62) @(negedge clk);
    check("to_before", timeout_err, 0);
    @(negedge clk);
    check("to_rise", timeout_err, 1);
    repeat (20) @(negedge clk);
    check("to_sticky", timeout_err, 1);
    check("to_busy", busy, 1);
    mem_mute = 1'b0;
    do_reset(1'b1);
    check("to_cleared", timeout_err, 0);
`endif

    // Random traffic: ready, redirects (some near the top of memory) and latency.
    do_reset(1'b1);
    wstart = word_count;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 9) < 7);
      mem_delay = $urandom_range(0, 6);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else rpc = $urandom() & 32'hFFFF_FFFC;
      redirect_pc = rpc;
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    check("rand_progress", (word_count - wstart) >= 50, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
